// File: rtl/front_panel_seq_pkg.sv
// Front panel sequencer: shared major-state encodings, panel op codes
// and small state-group helpers.
package front_panel_seq_pkg;

  localparam logic [4:0] ST_H0 = 5'd0;
  localparam logic [4:0] ST_H1 = 5'd1;
  localparam logic [4:0] ST_H2 = 5'd2;
  localparam logic [4:0] ST_H3 = 5'd3;
  localparam logic [4:0] ST_HW = 5'd4;
  localparam logic [4:0] ST_F0 = 5'd5;
  localparam logic [4:0] ST_F1 = 5'd6;
  localparam logic [4:0] ST_FW = 5'd7;
  localparam logic [4:0] ST_D0 = 5'd8;
  localparam logic [4:0] ST_D1 = 5'd9;
  localparam logic [4:0] ST_DW = 5'd10;
  localparam logic [4:0] ST_E0 = 5'd11;
  localparam logic [4:0] ST_E1 = 5'd12;
  localparam logic [4:0] ST_EW = 5'd13;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LA   = 2'b01;
  localparam logic [1:0] OP_DEP  = 2'b10;
  localparam logic [1:0] OP_EXAM = 2'b11;

  localparam int SW_HALT  = 0;
  localparam int SW_SSTEP = 1;
  localparam int SW_CONT  = 2;
  localparam int SW_LA    = 3;
  localparam int SW_DEP   = 4;
  localparam int SW_EXAM  = 5;
  localparam int SW_NUM   = 6;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CONT_REQ,
    SEQ_TRIG_REQ,
    SEQ_TRIG_RUN
  } seq_e;

  function automatic logic in_hgroup(
    input logic [4:0] s
  );
    return s inside {ST_H0, ST_HW, ST_H1, ST_H2, ST_H3};
  endfunction

  function automatic logic cont_ok(
    input logic [4:0] s
  );
    return s inside {ST_H0, ST_HW, ST_F0, ST_D0, ST_E0};
  endfunction

  function automatic logic trig_ok(
    input logic [4:0] s
  );
    return s inside {ST_H0, ST_HW};
  endfunction

  function automatic logic cont_done(
    input logic [4:0] s
  );
    return s inside {ST_FW, ST_DW, ST_EW};
  endfunction

endpackage

// File: rtl/front_panel_seq_debounce.sv
// One panel input: 2-flop synchroniser, stability counter, debounced
// level and a press pulse that needs a seen release since reset.
module front_panel_seq_debounce
  import front_panel_seq_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [CW-1:0] arm_cnt;
  logic          done;

  assign done  = (s2 != db) && (cnt == LAST);
  assign level = db;
  assign rise  = done & s2 & armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      cnt     <= '0;
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (done) begin
        cnt <= '0;
        db  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // a press only counts once the input was seen released
      if (!armed) begin
        if (done && !s2) begin
          armed <= 1'b1;
        end else if (!s2 && !db) begin
          if (arm_cnt == LAST) armed <= 1'b1;
          else arm_cnt <= arm_cnt + 1'b1;
        end else begin
          arm_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/front_panel_seq.sv
// Front panel sequencer: debounces the panel switches and turns button
// presses into cont / trigger requests for the processor state machine.
module front_panel_seq
  import front_panel_seq_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_halt,
  input  logic       sw_sing_step,
  input  logic       sw_cont,
  input  logic       sw_load_addr,
  input  logic       sw_dep,
  input  logic       sw_exam,
  input  logic [4:0] state,
  output logic       halt,
  output logic       single_step,
  output logic       cont,
  output logic       trigger,
  output logic [1:0] panel_op,
  output logic       busy
);

  logic [SW_NUM-1:0] raw;
  logic [SW_NUM-1:0] lvl;
  logic [SW_NUM-1:0] rise;

  assign raw = {sw_exam, sw_dep, sw_load_addr,
                sw_cont, sw_sing_step, sw_halt};

  for (genvar i = 0; i < SW_NUM; i++) begin : g_db
    front_panel_seq_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  logic unused_ok;
  assign unused_ok = ^{lvl[SW_EXAM:SW_CONT],
                       rise[SW_SSTEP:SW_HALT]};

  assign halt        = lvl[SW_HALT];
  assign single_step = lvl[SW_SSTEP];

  logic       ev_cont;
  logic       ev_trig;
  logic [1:0] trig_op;

  assign ev_cont = rise[SW_CONT];
  assign ev_trig = |rise[SW_EXAM:SW_LA];

  always_comb begin
    trig_op = OP_NONE;
    if (rise[SW_LA])        trig_op = OP_LA;
    else if (rise[SW_DEP])  trig_op = OP_DEP;
    else if (rise[SW_EXAM]) trig_op = OP_EXAM;
  end

  seq_e       seq_q;
  seq_e       seq_d;
  logic [1:0] op_q;
  logic [1:0] op_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= SEQ_IDLE;
      op_q  <= OP_NONE;
    end else begin
      seq_q <= seq_d;
      op_q  <= op_d;
    end
  end

  always_comb begin
    seq_d = seq_q;
    op_d  = op_q;
    case (seq_q)
      SEQ_IDLE: begin
        // cont beats any trigger in the same cycle
        if (ev_cont) begin
          if (cont_ok(state)) seq_d = SEQ_CONT_REQ;
        end else if (ev_trig && trig_ok(state)) begin
          seq_d = SEQ_TRIG_REQ;
          op_d  = trig_op;
        end
      end
      SEQ_CONT_REQ: begin
        if (cont_done(state)) seq_d = SEQ_IDLE;
      end
      SEQ_TRIG_REQ: begin
        if (!in_hgroup(state)) begin
          seq_d = SEQ_IDLE;
          op_d  = OP_NONE;
        end else if (state == ST_H1) begin
          seq_d = SEQ_TRIG_RUN;
        end
      end
      SEQ_TRIG_RUN: begin
        if (!in_hgroup(state) || state == ST_H0) begin
          seq_d = SEQ_IDLE;
          op_d  = OP_NONE;
        end
      end
      default: begin
        seq_d = SEQ_IDLE;
        op_d  = OP_NONE;
      end
    endcase
  end

  always_comb begin
    cont     = 1'b0;
    trigger  = 1'b0;
    busy     = 1'b0;
    panel_op = op_q;
    unique case (1'b1)
      seq_q == SEQ_CONT_REQ: cont    = 1'b1;
      seq_q == SEQ_TRIG_REQ: trigger = 1'b1;
      default: ;
    endcase
    if (seq_q != SEQ_IDLE) busy = 1'b1;
  end

endmodule

// File: tb/tb_front_panel_seq.sv
// Bench for front_panel_seq: vector table, hand-written corner sequences
// and a random run against a behavioural model of the panel rules.
module tb_front_panel_seq;
  import front_panel_seq_pkg::*;

  localparam int DB = 4;
  localparam logic [5:0] B_HALT = 6'h01;
  localparam logic [5:0] B_SS   = 6'h02;
  localparam logic [5:0] B_CONT = 6'h04;
  localparam logic [5:0] B_LA   = 6'h08;
  localparam logic [5:0] B_DEP  = 6'h10;
  localparam logic [5:0] B_EXAM = 6'h20;

  logic       clk = 1'b0;
  logic       reset;
  logic       sw_halt, sw_sing_step, sw_cont;
  logic       sw_load_addr, sw_dep, sw_exam;
  logic [4:0] state;
  logic       halt, single_step, cont, trigger, busy;
  logic [1:0] panel_op;

  always #5 clk = ~clk;

  front_panel_seq #(
    .DB_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_halt     (sw_halt),
    .sw_sing_step(sw_sing_step),
    .sw_cont     (sw_cont),
    .sw_load_addr(sw_load_addr),
    .sw_dep      (sw_dep),
    .sw_exam     (sw_exam),
    .state       (state),
    .halt        (halt),
    .single_step (single_step),
    .cont        (cont),
    .trigger     (trigger),
    .panel_op    (panel_op),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_raw(input logic [5:0] r);
    {sw_exam, sw_dep, sw_load_addr, sw_cont, sw_sing_step, sw_halt} = r;
  endtask

  function automatic logic [5:0] get_raw();
    return {sw_exam, sw_dep, sw_load_addr, sw_cont, sw_sing_step, sw_halt};
  endfunction

  function automatic int outs();
    return int'({halt, single_step, cont, trigger, panel_op, busy});
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_out(input int which, input int bound, output int lat);
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      tick(1);
      if ((which == 0 ? cont : trigger) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int   cont_rises = 0;
  logic cont_prev  = 1'b0;
  always @(negedge clk) begin
    if (cont === 1'b1 && cont_prev !== 1'b1) cont_rises++;
    cont_prev = cont;
  end

  typedef struct packed {
    logic [5:0] raw;
    logic [4:0] st;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[18];

  // behavioural model state for the random run
  logic [7:0] hist[6];
  logic [5:0] dbm;
  logic [5:0] ev;
  int         mode;
  logic [1:0] mop;
  logic [4:0] st_list[14];

  int lat;
  int base;

  initial begin
    // {halt, single_step, cont, trigger, panel_op, busy}
    vecs[0]  = '{B_CONT,        ST_HW, 7'b0010001};
    vecs[1]  = '{B_CONT,        ST_H0, 7'b0010001};
    vecs[2]  = '{B_CONT,        ST_F0, 7'b0010001};
    vecs[3]  = '{B_CONT,        ST_D0, 7'b0010001};
    vecs[4]  = '{B_CONT,        ST_E0, 7'b0010001};
    vecs[5]  = '{B_CONT,        ST_H1, 7'b0000000};
    vecs[6]  = '{B_CONT,        ST_FW, 7'b0000000};
    vecs[7]  = '{B_LA,          ST_H0, 7'b0001011};
    vecs[8]  = '{B_DEP,         ST_HW, 7'b0001101};
    vecs[9]  = '{B_EXAM,        ST_H0, 7'b0001111};
    vecs[10] = '{B_EXAM,        ST_E1, 7'b0000000};
    vecs[11] = '{B_LA | B_EXAM, ST_HW, 7'b0001011};
    vecs[12] = '{B_DEP | B_EXAM,ST_H0, 7'b0001101};
    vecs[13] = '{B_CONT | B_LA, ST_HW, 7'b0010001};
    vecs[14] = '{B_DEP,         ST_F0, 7'b0000000};
    vecs[15] = '{B_HALT,        ST_H2, 7'b1000000};
    vecs[16] = '{B_SS | B_HALT, ST_H3, 7'b1100000};
    vecs[17] = '{B_LA,          ST_H3, 7'b0000000};

    st_list = '{ST_H0, ST_H1, ST_H2, ST_H3, ST_HW, ST_F0, ST_F1,
                ST_FW, ST_D0, ST_D1, ST_DW, ST_E0, ST_E1, ST_EW};

    // reset state
    set_raw(6'h00);
    state = ST_H0;
    reset = 1'b1;
    tick(3);
    check("reset_outputs", outs(), 0);
    reset = 1'b0;
    tick(DB + 8);

    // vector table: steady outputs after one press pattern
    for (int v = 0; v < 18; v++) begin
      set_raw(6'h00);
      state = vecs[v].st;
      do_reset();
      tick(DB + 8);
      set_raw(vecs[v].raw);
      tick(DB + 6);
      check($sformatf("vec%0d", v), outs(), int'(vecs[v].exp));
    end

    // bouncing cont in HW, then the F0 -> FW handshake
    set_raw(6'h00);
    state = ST_HW;
    do_reset();
    tick(DB + 8);
    base = cont_rises;
    set_raw(B_CONT);
    tick(3);
    set_raw(6'h00);
    tick(1);
    set_raw(B_CONT);
    wait_out(0, 20, lat);
    check("bounce_latency", lat, DB + 2);
    tick(2);
    check("bounce_single", cont_rises - base, 1);
    check("cont_hw", int'({cont, busy}), 3);
    state = ST_F0;
    tick(1);
    check("cont_f0", int'({cont, busy}), 3);
    state = ST_FW;
    tick(1);
    check("cont_after_fw", int'({cont, trigger, busy}), 0);
    state = ST_F1;
    set_raw(6'h00);
    tick(DB + 6);
    check("cont_once", cont_rises - base, 1);

    // deposit: request, run through H1..H3, done at H0
    state = ST_H0;
    set_raw(B_DEP);
    wait_out(1, 20, lat);
    check("dep_latency", lat, DB + 2);
    check("dep_req", int'({cont, trigger, panel_op, busy}), 5'b0_1_10_1);
    set_raw(6'h00);
    state = ST_HW;
    tick(1);
    check("dep_hw", int'({trigger, panel_op}), 3'b1_10);
    state = ST_H1;
    tick(1);
    check("dep_h1", int'({trigger, panel_op, busy}), 4'b0_10_1);
    state = ST_H2;
    tick(1);
    check("dep_h2", int'({trigger, panel_op, busy}), 4'b0_10_1);
    state = ST_H3;
    tick(1);
    check("dep_h3", int'({trigger, panel_op, busy}), 4'b0_10_1);
    state = ST_H0;
    tick(1);
    check("dep_done", int'({trigger, panel_op, busy}), 0);
    tick(DB + 6);

    // LA + EXAM together, then EXAM during run is dropped
    state = ST_HW;
    set_raw(B_LA | B_EXAM);
    wait_out(1, 20, lat);
    check("la_exam_latency", lat, DB + 2);
    check("la_exam_op", int'(panel_op), int'(OP_LA));
    set_raw(6'h00);
    tick(DB + 4);
    state = ST_H1;
    tick(1);
    check("la_run", int'({trigger, panel_op, busy}), 4'b0_01_1);
    state = ST_H2;
    set_raw(B_EXAM);
    tick(DB + 6);
    check("exam_ignored", int'({trigger, panel_op, busy}), 4'b0_01_1);
    state = ST_H0;
    tick(1);
    check("la_done", int'({trigger, panel_op, busy}), 0);
    tick(5);
    check("exam_not_queued", int'({trigger, busy}), 0);
    set_raw(6'h00);
    tick(DB + 6);

    // abort when the machine leaves the H group
    state = ST_H0;
    set_raw(B_LA);
    wait_out(1, 20, lat);
    check("abort_req", lat, DB + 2);
    set_raw(6'h00);
    state = ST_F0;
    tick(1);
    check("abort", int'({trigger, panel_op, busy}), 0);
    tick(DB + 6);

    // reset during cont request with the button held
    state = ST_HW;
    base = cont_rises;
    set_raw(B_CONT);
    wait_out(0, 20, lat);
    check("pre_reset_cont", lat, DB + 2);
    reset = 1'b1;
    tick(1);
    check("reset_drop", int'({cont, busy}), 0);
    reset = 1'b0;
    tick(20);
    check("held_no_event", int'({cont, busy}), 0);
    check("held_rises", cont_rises - base, 1);
    set_raw(6'h00);
    tick(DB + 6);
    set_raw(B_CONT);
    wait_out(0, 20, lat);
    check("repress_latency", lat, DB + 2);

    // random run against the behavioural model
    set_raw(6'h00);
    state = ST_H0;
    do_reset();
    tick(DB + 8);
    for (int i = 0; i < 6; i++) hist[i] = 8'h00;
    dbm  = 6'h00;
    mode = 0;
    mop  = OP_NONE;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0] r;
      logic [4:0] s;
      logic       hg;
      logic       alldiff;
      logic [6:0] exp;
      r = get_raw();
      s = state;
      tick(1);
      ev = 6'h00;
      for (int i = 0; i < 6; i++) begin
        hist[i] = {hist[i][6:0], r[i]};
        alldiff = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (hist[i][k] == dbm[i]) alldiff = 1'b0;
        if (alldiff) begin
          dbm[i] = ~dbm[i];
          ev[i]  = dbm[i];
        end
      end
      hg = s inside {ST_H0, ST_HW, ST_H1, ST_H2, ST_H3};
      case (mode)
        0: begin
          if (ev[2]) begin
            if (s inside {ST_H0, ST_HW, ST_F0, ST_D0, ST_E0}) mode = 1;
          end else if ((|ev[5:3]) && (s inside {ST_H0, ST_HW})) begin
            mode = 2;
            mop  = ev[3] ? OP_LA : (ev[4] ? OP_DEP : OP_EXAM);
          end
        end
        1: if (s inside {ST_FW, ST_DW, ST_EW}) mode = 0;
        2: begin
          if (!hg) begin
            mode = 0;
            mop  = OP_NONE;
          end else if (s == ST_H1) begin
            mode = 3;
          end
        end
        default: begin
          if (!hg || s == ST_H0) begin
            mode = 0;
            mop  = OP_NONE;
          end
        end
      endcase
      exp = {dbm[0], dbm[1], mode == 1, mode == 2, mop, mode != 0};
      check($sformatf("rand%0d", cyc), outs(), int'(exp));
      if (cont === 1'b1 && trigger === 1'b1) check("cont_trig_excl", 1, 0);
      r = get_raw();
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 29) == 0) r[i] = ~r[i];
      set_raw(r);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) state = st_list[$urandom_range(0, 4)];
        else state = st_list[$urandom_range(0, 13)];
      end
    end

    // reset at the end returns everything to zero
    reset = 1'b1;
    tick(2);
    check("final_reset", int'({cont, trigger, panel_op, busy}), 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/front_panel_seq.md
FRONT_PANEL_SEQ -- requirements
Module: front_panel_seq

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, meaning consecutive stable cycles required to accept a switch change (1 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports sw_halt, sw_sing_step  input  1 each  raw asynchronous toggle switches.
REQ-005 SHALL have ports sw_cont, sw_load_addr, sw_dep, sw_exam  input  1 each  raw asynchronous momentary buttons.
REQ-006 SHALL have port state  input  5  major state from the processor state machine.
REQ-007 SHALL have ports halt, single_step  output  1 each  debounced switch levels.
REQ-008 SHALL have port cont  output  1  continue request to the processor state machine.
REQ-009 SHALL have port trigger  output  1  panel-operation request, honoured by the state machine in HW.
REQ-010 SHALL have port panel_op  output  2  operation code: 01 LA, 10 DEP, 11 EXAM, 00 none.
REQ-011 SHALL have port busy  output  1  high while any request is outstanding.

Function
REQ-012 Each of the six raw inputs SHALL pass a 2-flop synchroniser and then a debouncer: the debounced value changes only after the synchronised value differs from it for DB_CYCLES consecutive cycles; any intermediate match restarts the count.
REQ-013 halt and single_step SHALL equal the debounced sw_halt and sw_sing_step levels.
REQ-014 A button press event SHALL be one debounced 0->1 edge; a new event from the same button requires a debounced release first.
REQ-015 Sequencer states SHALL be IDLE, CONT_REQ, TRIG_REQ and TRIG_RUN.
REQ-016 IDLE + cont event + state in {H0, HW, F0, D0, E0} -> CONT_REQ; the event is discarded in any other state.
REQ-017 CONT_REQ SHALL drive cont=1 and move to IDLE on the cycle after state is FW, DW or EW, so cont spans HW->F0->FW.
REQ-018 IDLE + LA/DEP/EXAM event + state in {H0, HW} -> TRIG_REQ with panel_op latched; the event is discarded in any other state.
REQ-019 Simultaneous trigger events SHALL take priority LA > DEP > EXAM; the losing events are discarded.
REQ-020 cont and trigger events in the same cycle: cont wins and the trigger event is discarded.
REQ-021 Events arriving while not in IDLE SHALL be discarded, not queued.
REQ-022 TRIG_REQ SHALL drive trigger=1 until state is H1, then go to TRIG_RUN with trigger=0.
REQ-023 TRIG_RUN SHALL hold panel_op until state returns to H0, then return to IDLE with panel_op=00.
REQ-024 In TRIG_REQ/TRIG_RUN, if state leaves the H-group (H0,HW,H1,H2,H3), the sequencer SHALL abort to IDLE with trigger=0 and panel_op=00.
REQ-025 busy SHALL be 1 exactly when the sequencer is not in IDLE.
REQ-026 cont and trigger SHALL never be 1 in the same cycle.

Reset
REQ-027 On reset, synchronisers and debounced values SHALL go to 0, counters to 0, and the sequencer to IDLE.
REQ-028 On reset, all outputs SHALL be 0 (panel_op=00).
REQ-029 Reset mid-request SHALL drop the request with no residual pulse afterwards.
REQ-030 A button held through reset SHALL not generate an event until it is released and pressed again.

Structure
REQ-031 Major-state encodings (H0..H3, HW, F0, FW, D0, DW, E0, EW) SHALL come from the shared parameters include; panel_op codes SHALL be added there as well.
REQ-032 Exactly one sub-module, debounce (synchroniser + counter + edge output), SHALL be instantiated six times.
REQ-033 Total RTL SHALL be 120-400 lines.

Verification (DB_CYCLES=4 for simulation)
REQ-034 Bounce sw_cont 3 cycles high / 1 low, then hold high, with state=HW -> exactly one cont assertion starting 4+2 cycles after the stable edge.
REQ-035 state=HW, press cont; model steps HW->F0->FW -> cont=1 through FW, 0 the next cycle, busy follows cont.
REQ-036 state=H0, press sw_dep -> trigger=1, panel_op=10; model goes HW->H1 -> trigger=0; panel_op stays 10 through H3, then 00 at H0.
REQ-037 sw_load_addr and sw_exam debounced on the same cycle in HW -> panel_op=01 only; a second EXAM press during TRIG_RUN is ignored.
REQ-038 Press sw_exam while state=E1 (running) -> no trigger, busy stays 0.
REQ-039 Assert reset while in CONT_REQ holding cont -> cont=0 next cycle, held button produces no event until release and re-press.
